instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 74 +++++++
 tb/tb_instr_fetch.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction memory read port, issue handshake and
// the branch decode/flags returned by the control unit and datapath.
interface instr_fetch_if;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [2:0] OPCode;
  logic [4:0] operand;
  logic       issue_valid;
  logic       issue_ready;
  logic       J;
  logic       JC;
  logic       NEQ;
  logic       eq_flag;
  logic [7:0] jump_target;

  modport master (
    output imem_req, imem_addr, OPCode, operand, issue_valid,
    input  imem_ack, imem_data, issue_ready, J, JC, NEQ, eq_flag, jump_target
  );

  modport slave (
    input  imem_req, imem_addr, OPCode, operand, issue_valid,
    output imem_ack, imem_data, issue_ready, J, JC, NEQ, eq_flag, jump_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch/issue sequencer (IDLE -> FETCH -> ISSUE) with branch resolve.
// Optional fetch timeout/retry is enabled by defining IFETCH_TIMEOUT_EN.
module instr_fetch (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic [7:0]    pc,
  output logic          fetch_err,
  instr_fetch_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  logic [1:0] state;
  logic [7:0] ir;
  logic       taken;

  assign taken           = bus.J | (bus.JC & (bus.eq_flag ^ bus.NEQ));
  // the timeout pulse cycle doubles as a one-cycle request gap before retry
  assign bus.imem_req    = (state == FETCH) & ~fetch_err;
  assign bus.imem_addr   = pc;
  assign bus.OPCode      = ir[7:5];
  assign bus.operand     = ir[4:0];
  assign bus.issue_valid = (state == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= 8'h00;
      ir    <= 8'h00;
    end else begin
      case (state)
        IDLE:  if (run) state <= FETCH;
        FETCH: if (bus.imem_req && bus.imem_ack) begin
                 ir    <= bus.imem_data;
                 state <= ISSUE;
               end
        ISSUE: if (bus.issue_ready) begin
                 pc    <= taken ? bus.jump_target : pc + 8'd1;
                 state <= run ? FETCH : IDLE;
               end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  logic [3:0] to_cnt;

  // counter is held at 0 outside FETCH, so every FETCH entry starts fresh;
  // an ack on the 16th cycle is taken by the FSM before the timeout fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= 4'd0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      if (state != FETCH || fetch_err || bus.imem_ack) begin
        to_cnt <= 4'd0;
      end else if (to_cnt == 4'hF) begin
        to_cnt    <= 4'd0;
        fetch_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 4'd1;
      end
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed test of instr_fetch: reset, fetch/issue, branches, wrap, stall,
// run stop, fetch timeout (or its absence) and asynchronous reset mid-fetch.
module tb_instr_fetch;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] pc;
  logic       fetch_err;
  int         total = 0;
  int         bad = 0;

  instr_fetch_if bus();

  instr_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .pc        (pc),
    .fetch_err (fetch_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full instruction starting in FETCH: ack with d, then complete issue
  task automatic instr(input logic [7:0] d, input logic j, input logic jc,
                       input logic neq, input logic eq, input logic [7:0] tgt);
    bus.imem_ack  = 1'b1;
    bus.imem_data = d;
    tick();
    bus.imem_ack    = 1'b0;
    bus.J           = j;
    bus.JC          = jc;
    bus.NEQ         = neq;
    bus.eq_flag     = eq;
    bus.jump_target = tgt;
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    bus.J           = 1'b0;
    bus.JC          = 1'b0;
    bus.NEQ         = 1'b0;
    bus.eq_flag     = 1'b0;
  endtask

  initial begin
    logic       eqv  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       neqv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] expv [4] = '{8'h80, 8'h21, 8'h80, 8'h21};

    rst_n = 1'b0;
    run   = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_data   = 8'h00;
    bus.issue_ready = 1'b0;
    bus.J           = 1'b0;
    bus.JC          = 1'b0;
    bus.NEQ         = 1'b0;
    bus.eq_flag     = 1'b0;
    bus.jump_target = 8'h00;
    #2;
    chk("rst_pc", pc, 8'h00);
    chk("rst_req", {7'd0, bus.imem_req}, 8'h00);
    chk("rst_addr", bus.imem_addr, 8'h00);
    chk("rst_valid", {7'd0, bus.issue_valid}, 8'h00);
    chk("rst_opc", {5'd0, bus.OPCode}, 8'h00);
    chk("rst_opnd", {3'd0, bus.operand}, 8'h00);
    chk("rst_err", {7'd0, fetch_err}, 8'h00);

    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_req", {7'd0, bus.imem_req}, 8'h00);
    run = 1'b1;
    tick();
    chk("f0_req", {7'd0, bus.imem_req}, 8'h01);
    chk("f0_addr", bus.imem_addr, 8'h00);

    bus.imem_ack  = 1'b1;
    bus.imem_data = 8'h25;
    tick();
    bus.imem_ack = 1'b0;
    chk("i0_valid", {7'd0, bus.issue_valid}, 8'h01);
    chk("i0_opc", {5'd0, bus.OPCode}, 8'h01);
    chk("i0_opnd", {3'd0, bus.operand}, 8'h05);
    chk("i0_req", {7'd0, bus.imem_req}, 8'h00);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    chk("seq_pc", pc, 8'h01);
    chk("seq_req", {7'd0, bus.imem_req}, 8'h01);
    chk("post_valid", {7'd0, bus.issue_valid}, 8'h00);
    chk("post_opc", {5'd0, bus.OPCode}, 8'h01);

    instr(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
    chk("jmp_10", pc, 8'h10);
    instr(8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    chk("jmp_addr_3c", bus.imem_addr, 8'h3C);

    for (int k = 0; k < 4; k++) begin
      instr(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20);
      chk("br_setup", pc, 8'h20);
      instr(8'h40, 1'b0, 1'b1, neqv[k], eqv[k], 8'h80);
      chk($sformatf("jc_case%0d", k), pc, expv[k]);
    end

    instr(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20);
    instr(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80);
    chk("j_force", pc, 8'h80);

    instr(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    chk("to_ff", pc, 8'hFF);
    instr(8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44);
    chk("wrap", pc, 8'h00);

    bus.imem_ack  = 1'b1;
    bus.imem_data = 8'hE7;
    tick();
    bus.imem_data = 8'h18;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", {7'd0, bus.issue_valid}, 8'h01);
      chk("stall_opc", {5'd0, bus.OPCode}, 8'h07);
      chk("stall_opnd", {3'd0, bus.operand}, 8'h07);
      chk("stall_req", {7'd0, bus.imem_req}, 8'h00);
    end
    bus.imem_ack    = 1'b0;
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    chk("stall_pc", pc, 8'h01);

    run = 1'b0;
    tick();
    chk("run0_fetch_req", {7'd0, bus.imem_req}, 8'h01);
    bus.imem_ack  = 1'b1;
    bus.imem_data = 8'h55;
    tick();
    bus.imem_ack = 1'b0;
    chk("run0_valid", {7'd0, bus.issue_valid}, 8'h01);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    chk("run0_pc", pc, 8'h02);
    chk("run0_idle_req", {7'd0, bus.imem_req}, 8'h00);
    tick();
    chk("run0_stay_idle", {7'd0, bus.imem_req}, 8'h00);

    run = 1'b1;
    tick();
`ifdef IFETCH_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      chk("to_wait_err", {7'd0, fetch_err}, 8'h00);
      chk("to_wait_req", {7'd0, bus.imem_req}, 8'h01);
      tick();
    end
    chk("to_c16_err", {7'd0, fetch_err}, 8'h00);
    tick();
    chk("to_pulse_err", {7'd0, fetch_err}, 8'h01);
    chk("to_pulse_req", {7'd0, bus.imem_req}, 8'h00);
    chk("to_pulse_pc", pc, 8'h02);
    tick();
    chk("to_retry_err", {7'd0, fetch_err}, 8'h00);
    chk("to_retry_req", {7'd0, bus.imem_req}, 8'h01);
    chk("to_retry_addr", bus.imem_addr, 8'h02);
    for (int k = 0; k < 15; k++) tick();
    bus.imem_ack  = 1'b1;
    bus.imem_data = 8'h66;
    tick();
    bus.imem_ack = 1'b0;
    chk("ack16_err", {7'd0, fetch_err}, 8'h00);
    chk("ack16_valid", {7'd0, bus.issue_valid}, 8'h01);
    chk("ack16_opnd", {3'd0, bus.operand}, 8'h06);
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("noto_err", {7'd0, fetch_err}, 8'h00);
      chk("noto_req", {7'd0, bus.imem_req}, 8'h01);
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = 8'h66;
    tick();
    bus.imem_ack = 1'b0;
    chk("noto_valid", {7'd0, bus.issue_valid}, 8'h01);
    chk("noto_opnd", {3'd0, bus.operand}, 8'h06);
`endif
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    chk("pre_rst_pc", pc, 8'h03);
    chk("pre_rst_req", {7'd0, bus.imem_req}, 8'h01);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {7'd0, bus.imem_req}, 8'h00);
    chk("arst_pc", pc, 8'h00);
    chk("arst_opc", {5'd0, bus.OPCode}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rerun_req", {7'd0, bus.imem_req}, 8'h01);
    chk("rerun_addr", bus.imem_addr, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
